// File: rtl/redpitaya_pll_drp_ctrl.sv
// PLLE2_ADV DRP sequencer: holds the PLL in reset, read-modify-writes DRP
// registers, releases reset and waits for LOCKED. Runs on the buffered adc_clk.
//
// state     | meaning
// IDLE      | waiting for a request
// HOLD      | PLL reset asserted before the first DRP access
// RD        | DRP read strobe
// RD_WAIT   | waiting for read DRDY
// WR        | DRP write strobe with merged data
// WR_WAIT   | waiting for write DRDY
// NEXT      | batch open, PLL kept in reset, waiting for the next request
// RELEASE   | PLL reset deasserted
// LOCK_WAIT | ignore window, then wait for LOCKED
// ABORT     | DRDY timeout, release PLL and flag error
module redpitaya_pll_drp_ctrl #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [6:0]  cfg_addr_i,
    input  logic [15:0] cfg_data_i,
    input  logic [15:0] cfg_mask_i,
    input  logic        cfg_last_i,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int DW = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(RST_HOLD - 1);
    localparam logic [DW-1:0] DRDY_LD = DW'(DRDY_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LD = LW'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_NEXT,
        S_RELEASE,
        S_LOCK_WAIT,
        S_ABORT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            cfg_ready;
    logic            drp_den;
    logic            lock_ok;
    logic            lock_to;

    logic [6:0]      addr_q;
    logic [15:0]     data_q;
    logic [15:0]     mask_q;
    logic            last_q;
    logic [15:0]     merged_q;
    logic            dwe_q;
    logic            pll_rst_q;
    logic            done_q;
    logic            err_q;
    logic [1:0]      err_code_q;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   drdy_cnt;
    logic [LW-1:0]   lock_cnt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cfg_ready = 1'b0;
        drp_den   = 1'b0;
        lock_ok   = 1'b0;
        lock_to   = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) state_nxt = S_RD;
            end
            S_RD: begin
                drp_den   = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy_i)           state_nxt = S_WR;
                else if (drdy_cnt == '0)  state_nxt = S_ABORT;
            end
            S_WR: begin
                drp_den   = 1'b1;
                state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy_i)           state_nxt = last_q ? S_RELEASE : S_NEXT;
                else if (drdy_cnt == '0)  state_nxt = S_ABORT;
            end
            S_NEXT: begin
                cfg_ready = 1'b1;
                if (cfg_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_RD;
                end
            end
            S_RELEASE: begin
                state_nxt = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                // LOCKED only counts once the post-release ignore window has run out
                if (hold_cnt == '0 && pll_locked_i) begin
                    lock_ok   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (lock_cnt == '0) begin
                    lock_to   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ABORT: begin
                state_nxt = S_LOCK_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            merged_q   <= '0;
            dwe_q      <= 1'b0;
            pll_rst_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            hold_cnt   <= HOLD_LD;
            drdy_cnt   <= DRDY_LD;
            lock_cnt   <= LOCK_LD;
        end else begin
            state <= state_nxt;

            if (accept) begin
                addr_q <= cfg_addr_i;
                data_q <= cfg_data_i;
                mask_q <= cfg_mask_i;
                last_q <= cfg_last_i;
            end
            if (accept && state == S_IDLE) begin
                err_q      <= 1'b0;
                err_code_q <= 2'b00;
                pll_rst_q  <= 1'b1;
            end
            if (state_nxt == S_RELEASE) pll_rst_q <= 1'b0;
            if (state_nxt == S_ABORT) begin
                pll_rst_q  <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
            end
            // a DRDY timeout code takes precedence over a later lock timeout
            if (lock_to) begin
                err_q <= 1'b1;
                if (err_code_q != 2'b01) err_code_q <= 2'b10;
            end
            done_q <= lock_ok && !err_q;

            if (state == S_RD_WAIT && drp_drdy_i)
                merged_q <= (drp_do_i & mask_q) | (data_q & ~mask_q);
            if (state_nxt == S_RD)      dwe_q <= 1'b0;
            else if (state_nxt == S_WR) dwe_q <= 1'b1;

            if (state == S_IDLE || state == S_RELEASE || state == S_ABORT)
                hold_cnt <= HOLD_LD;
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);

            if (state == S_RD || state == S_WR)
                drdy_cnt <= DRDY_LD;
            else if (drdy_cnt != '0)
                drdy_cnt <= drdy_cnt - DW'(1);

            if (state != S_LOCK_WAIT)
                lock_cnt <= LOCK_LD;
            else if (lock_cnt != '0)
                lock_cnt <= lock_cnt - LW'(1);
        end
    end

    assign cfg_ready_o = cfg_ready;
    assign drp_den_o   = drp_den;
    assign drp_daddr_o = addr_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_di_o    = merged_q;
    assign pll_rst_o   = pll_rst_q;
    assign busy_o      = (state != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_redpitaya_pll_drp_ctrl.sv
// Bench for redpitaya_pll_drp_ctrl: randomized requests against a behavioural
// PLL/DRP model and a shadow register map predicting every written word.
module tb_redpitaya_pll_drp_ctrl;

    localparam int RST_HOLD = 4;
    localparam int DRDY_TO  = 64;
    localparam int LOCK_TO  = 300;

    logic        adc_clk_i    = 1'b0;
    logic        adc_rst_i    = 1'b1;
    logic        cfg_valid_i  = 1'b0;
    logic        cfg_ready_o;
    logic [6:0]  cfg_addr_i   = '0;
    logic [15:0] cfg_data_i   = '0;
    logic [15:0] cfg_mask_i   = '0;
    logic        cfg_last_i   = 1'b0;
    logic [6:0]  drp_daddr_o;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i     = '0;
    logic        drp_drdy_i   = 1'b0;
    logic        pll_rst_o;
    logic        pll_locked_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    redpitaya_pll_drp_ctrl #(
        .RST_HOLD     (RST_HOLD),
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .adc_clk_i    (adc_clk_i),
        .adc_rst_i    (adc_rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_mask_i   (cfg_mask_i),
        .cfg_last_i   (cfg_last_i),
        .drp_daddr_o  (drp_daddr_o),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .drp_di_o     (drp_di_o),
        .drp_do_i     (drp_do_i),
        .drp_drdy_i   (drp_drdy_i),
        .pll_rst_o    (pll_rst_o),
        .pll_locked_i (pll_locked_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } acc_t;

    acc_t        acc_q[$];
    acc_t        exp_q[$];
    logic [15:0] mem    [128];
    logic [15:0] shadow [128];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int lat_lo = 1, lat_hi = 4;
    bit hang = 1'b0;
    int lock_mode = 0;
    int lock_delay = 10;

    int den_cnt = 0, wr_den_cnt = 0, consec_viol = 0;
    int done_cnt = 0, done_cyc = 0, drop_cnt = 0, rel_cyc = 0, den_at_drop = 0;
    int rst_run = 0, rst_run_at_rd = 0, first_rd_cyc = -1, err_rise_cyc = 0;
    int since_rel = 0, pend_cnt = 0;
    bit pend = 1'b0, den_prev = 1'b0, rst_prev = 1'b0, err_prev = 1'b0;
    logic [15:0] pend_do = '0;

    always @(posedge adc_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // PLL model: DRP register file with response latency, LOCKED behaviour,
    // plus the event monitor feeding the checks.
    initial begin
        acc_t a;
        forever begin
            @(negedge adc_clk_i);
            drp_drdy_i = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = pend_do;
                    pend       = 1'b0;
                end
            end
            if (drp_den_o) begin
                a.we = drp_dwe_o; a.addr = drp_daddr_o; a.di = drp_di_o;
                acc_q.push_back(a);
                if (den_prev) consec_viol++;
                den_cnt++;
                if (drp_dwe_o) begin
                    wr_den_cnt++;
                    mem[drp_daddr_o] = drp_di_o;
                end else begin
                    rst_run_at_rd = rst_run;
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                end
                if (!(hang && !drp_dwe_o)) begin
                    pend     = 1'b1;
                    pend_cnt = $urandom_range(lat_hi, lat_lo);
                    pend_do  = drp_dwe_o ? 16'h0 : mem[drp_daddr_o];
                end
            end
            den_prev = drp_den_o;
            rst_run  = pll_rst_o ? rst_run + 1 : 0;
            if (rst_prev && !pll_rst_o) begin
                drop_cnt++;
                rel_cyc     = cyc;
                den_at_drop = den_cnt;
            end
            rst_prev = pll_rst_o;
            if (err_o && !err_prev) err_rise_cyc = cyc;
            err_prev = err_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pll_rst_o) since_rel = 0;
            else           since_rel++;
            case (lock_mode)
                2:       pll_locked_i = 1'b1;
                1:       pll_locked_i = 1'b0;
                default: pll_locked_i = !pll_rst_o && (since_rel > lock_delay);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge adc_clk_i);
            #1;
        end
    endtask

    task automatic send_req(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                            input logic l, input bit predict);
        int   n;
        acc_t e;
        n = 0;
        cfg_addr_i = a; cfg_data_i = d; cfg_mask_i = m; cfg_last_i = l;
        cfg_valid_i = 1'b1;
        while (!cfg_ready_o && n < 2000) begin
            tick(1);
            n++;
        end
        chk("accept_bound", (n < 2000), 1'b1);
        tick(1);
        cfg_valid_i = 1'b0;
        if (predict) begin
            e.we = 1'b0; e.addr = a; e.di = 16'h0;
            exp_q.push_back(e);
            e.we = 1'b1; e.di = (shadow[a] & m) | (d & ~m);
            shadow[a] = e.di;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_bound", (n < budget), 1'b1);
        tick(2);
    endtask

    task automatic compare_acc(input string tag);
        acc_t g, e;
        chk({tag, "_nacc"}, acc_q.size(), exp_q.size());
        while (acc_q.size() > 0 && exp_q.size() > 0) begin
            g = acc_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_we"}, g.we, e.we);
            chk({tag, "_addr"}, g.addr, e.addr);
            if (e.we) chk({tag, "_di"}, g.di, e.di);
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic run_batch(input string tag, input int nreq, input int gap);
        int n, done0, drop0, den0, lock_at;
        done0 = done_cnt; drop0 = drop_cnt; den0 = den_cnt;
        for (int i = 0; i < nreq; i++) begin
            send_req(7'($urandom), 16'($urandom), 16'($urandom), (i == nreq - 1), 1'b1);
            if (i < nreq - 1) begin
                n = 0;
                while (!cfg_ready_o && n < 500) begin
                    tick(1);
                    n++;
                end
                chk({tag, "_next_bound"}, (n < 500), 1'b1);
                tick(gap);
            end
        end
        wait_idle(LOCK_TO + 500);
        lock_at = (lock_delay > RST_HOLD) ? lock_delay : RST_HOLD;
        chk({tag, "_done_cnt"}, done_cnt - done0, 1);
        chk({tag, "_rst_drops"}, drop_cnt - drop0, 1);
        chk({tag, "_den_before_rel"}, den_at_drop - den0, 2 * nreq);
        chk({tag, "_done_time"}, done_cyc - rel_cyc, lock_at + 1);
        chk({tag, "_err"}, {err_o, err_code_o}, 3'b000);
        compare_acc(tag);
    endtask

    int  w0, d0, n;
    bit  bad;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 16'($urandom);
            shadow[i] = mem[i];
        end
        adc_rst_i = 1'b1;
        tick(3);
        chk("rst_ready", cfg_ready_o, 1'b1);
        chk("rst_outs", {busy_o, pll_rst_o, drp_den_o, drp_dwe_o, err_o, err_code_o, done_o}, 8'h00);
        chk("rst_drp_bus", {drp_daddr_o, drp_di_o}, 23'h0);
        adc_rst_i = 1'b0;
        tick(2);
        chk("idle_after_rst", {cfg_ready_o, busy_o, pll_rst_o}, 3'b100);

        // single write, known register content
        mem[8] = 16'h1082; shadow[8] = 16'h1082;
        lat_lo = 3; lat_hi = 3; lock_mode = 0; lock_delay = RST_HOLD + 20;
        d0 = done_cnt;
        send_req(7'h08, 16'h1041, 16'h1000, 1'b1, 1'b1);
        wait_idle(500);
        chk("t1_rst_before_den", rst_run_at_rd, RST_HOLD);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_done_late", (done_cyc - rel_cyc >= RST_HOLD + 20), 1'b1);
        chk("t1_done_time", done_cyc - rel_cyc, RST_HOLD + 21);
        chk("t1_err", err_o, 1'b0);
        chk("t1_mem", mem[8], 16'h1041);
        compare_acc("t1");

        // batch of three with 10-cycle gaps
        lat_lo = 1; lat_hi = 6; lock_delay = 12;
        run_batch("t2", 3, 10);

        // randomized batches
        for (int it = 0; it < 6; it++) begin
            lat_hi     = $urandom_range(10, 1);
            lock_delay = $urandom_range(30, 0);
            run_batch("rnd", $urandom_range(3, 1), $urandom_range(6, 0));
        end

        // read DRDY never returns; lock also never comes so code 01 must survive
        hang = 1'b1; lock_mode = 1; first_rd_cyc = -1;
        w0 = wr_den_cnt;
        send_req(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        n = 0;
        while (pll_rst_o && n < 300) begin
            tick(1);
            n++;
        end
        chk("t3_abort_bound", (n < 300), 1'b1);
        chk("t3_abort_err", {err_o, err_code_o}, 3'b101);
        chk("t3_abort_time", (rel_cyc - first_rd_cyc >= DRDY_TO) && (rel_cyc - first_rd_cyc <= DRDY_TO + 1), 1'b1);
        wait_idle(LOCK_TO + 200);
        chk("t3_code_kept", {busy_o, err_o, err_code_o}, 4'b0101);
        chk("t3_no_write", wr_den_cnt - w0, 0);
        acc_q.delete();
        hang = 1'b0;

        // lock timeout, then the next request clears the error
        lock_mode = 1; lat_hi = 4; d0 = done_cnt;
        send_req(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_idle(LOCK_TO + 200);
        chk("t4_lock_err", {busy_o, err_o, err_code_o}, 4'b0110);
        chk("t4_lock_time", (err_rise_cyc - rel_cyc >= LOCK_TO) && (err_rise_cyc - rel_cyc <= LOCK_TO + 2), 1'b1);
        chk("t4_no_done", done_cnt - d0, 0);
        compare_acc("t4a");
        lock_mode = 0; lock_delay = 5;
        send_req(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        chk("t4_err_cleared", {err_o, err_code_o}, 3'b000);
        wait_idle(500);
        chk("t4_done_cnt", done_cnt - d0, 1);
        compare_acc("t4b");

        // reset pulse in WR_WAIT with the write DRDY arriving afterwards
        lat_lo = 4; lat_hi = 4; d0 = done_cnt; w0 = wr_den_cnt;
        send_req(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        n = 0;
        while (wr_den_cnt == w0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("t5_wr_bound", (n < 200), 1'b1);
        tick(1);
        adc_rst_i = 1'b1;
        tick(1);
        adc_rst_i = 1'b0;
        chk("t5_idle_now", {cfg_ready_o, busy_o, pll_rst_o, drp_den_o, err_o}, 5'b10000);
        bad = 1'b0;
        repeat (6) begin
            tick(1);
            if (busy_o || !cfg_ready_o || pll_rst_o) bad = 1'b1;
        end
        chk("t5_late_drdy_ignored", bad, 1'b0);
        chk("t5_no_done", done_cnt - d0, 0);
        compare_acc("t5");

        // LOCKED stuck high through release
        lat_lo = 1; lat_hi = 5; lock_mode = 2; d0 = done_cnt;
        send_req(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_idle(500);
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_not_early", (done_cyc - rel_cyc >= RST_HOLD), 1'b1);
        chk("t6_done_time", done_cyc - rel_cyc, RST_HOLD + 1);
        compare_acc("t6");

        chk("den_back_to_back", consec_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
